// File: rtl/frame_ctrl_pkg.sv
// Shared types and constants for the frame controller that sits between
// the UART RX byte stream and the pixel data path.
package frame_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HDR    = 2'd1,
    CHECK  = 2'd2,
    STREAM = 2'd3
  } state_t;

  localparam logic [7:0] MAGIC   = 8'hA5;
  localparam logic [7:0] FID_SW  = 8'hFF;
  localparam int         HDR_LEN = 5;

  typedef logic [20:0] pix_cnt_t;

  // A dimension is usable when it is non-zero and no larger than the limit.
  function automatic logic dim_ok(input logic [15:0] d, input logic [15:0] max_d);
    return (d != 16'd0) && (d <= max_d);
  endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream style byte channel (tdata/tvalid/tready).
interface axis_if #(
  parameter int W = 8
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/idle_timer.sv
// Counts clk cycles since the last clear; expired flags the terminal count.
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expired
);

  localparam int             W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0]   TC = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Holds at the terminal count until the owner clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q != TC) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == TC);

endmodule

// File: rtl/frame_ctrl.sv
// Frame controller: finds a MAGIC-prefixed header in the byte stream, checks
// the image size and forwards exactly width*height pixel bytes downstream.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | discard bytes until MAGIC is accepted
//   HDR    | capture filter id, width lo/hi, height lo/hi
//   CHECK  | one-cycle header check, load pixel count and filter select
//   STREAM | zero-latency pass-through until the last pixel handshake
module frame_ctrl
  import frame_ctrl_pkg::*;
#(
  parameter int MAX_DIM        = 1024,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  sw_filter,
  axis_if.slave       axis_i,
  axis_if.master      axis_o,
  output logic        pix_last,
  output logic [3:0]  filter_sel,
  output logic        busy,
  output logic        err,
  output logic [15:0] frame_cnt
);

  localparam logic [15:0] MAX_DIM_W = 16'(MAX_DIM);
  localparam logic [2:0]  HDR_LAST  = 3'(HDR_LEN - 1);

  state_t      state_q, state_d;
  logic [2:0]  hdr_idx_q, hdr_idx_d;
  logic [7:0]  filt_id_q, filt_id_d;
  logic [15:0] width_q, width_d;
  logic [15:0] height_q, height_d;
  logic [3:0]  filter_sel_q, filter_sel_d;
  logic        err_q, err_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  pix_cnt_t    remaining_q, remaining_d;

  pix_cnt_t    total;
  logic        in_ready;
  logic        in_hs;
  logic        out_valid;
  logic        out_hs;
  logic        timer_clr;
  logic        timer_exp;

  assign total     = pix_cnt_t'(width_q) * pix_cnt_t'(height_q);

  assign in_ready  = (state_q == IDLE) || (state_q == HDR) ||
                     ((state_q == STREAM) && axis_o.tready);
  assign in_hs     = axis_i.tvalid && in_ready;
  assign out_valid = (state_q == STREAM) && axis_i.tvalid;
  assign out_hs    = out_valid && axis_o.tready;

  assign axis_i.tready = in_ready;
  assign axis_o.tdata  = axis_i.tdata;
  assign axis_o.tvalid = out_valid;

  assign pix_last   = out_valid && (remaining_q == pix_cnt_t'(1));
  assign filter_sel = filter_sel_q;
  assign busy       = (state_q != IDLE);
  assign err        = err_q;
  assign frame_cnt  = frame_cnt_q;

  // The timer only runs while waiting for bytes that belong to a frame.
  assign timer_clr = !((state_q == HDR) || (state_q == STREAM)) ||
                     in_hs || (state_d != state_q);

  idle_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clr),
    .expired (timer_exp)
  );

  always_comb begin
    state_d      = state_q;
    hdr_idx_d    = hdr_idx_q;
    filt_id_d    = filt_id_q;
    width_d      = width_q;
    height_d     = height_q;
    filter_sel_d = filter_sel_q;
    err_d        = err_q;
    frame_cnt_d  = frame_cnt_q;
    remaining_d  = remaining_q;

    unique case (state_q)
      IDLE: begin
        if (in_hs && (axis_i.tdata == MAGIC)) begin
          state_d   = HDR;
          hdr_idx_d = 3'd0;
        end
      end

      HDR: begin
        if (in_hs) begin
          case (hdr_idx_q)
            3'd0:    filt_id_d       = axis_i.tdata;
            3'd1:    width_d[7:0]    = axis_i.tdata;
            3'd2:    width_d[15:8]   = axis_i.tdata;
            3'd3:    height_d[7:0]   = axis_i.tdata;
            default: height_d[15:8]  = axis_i.tdata;
          endcase
          if (hdr_idx_q == HDR_LAST) begin
            state_d   = CHECK;
            hdr_idx_d = 3'd0;
          end else begin
            hdr_idx_d = hdr_idx_q + 3'd1;
          end
        end else if (timer_exp) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      CHECK: begin
        if (dim_ok(width_q, MAX_DIM_W) && dim_ok(height_q, MAX_DIM_W)) begin
          err_d        = 1'b0;
          remaining_d  = total;
          filter_sel_d = (filt_id_q == FID_SW) ? sw_filter : filt_id_q[3:0];
          state_d      = STREAM;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      STREAM: begin
        // An accepted beat beats a simultaneous timeout.
        if (out_hs) begin
          remaining_d = remaining_q - pix_cnt_t'(1);
          if (remaining_q == pix_cnt_t'(1)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = IDLE;
          end
        end else if (timer_exp) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hdr_idx_q    <= 3'd0;
      filt_id_q    <= 8'h00;
      width_q      <= 16'h0000;
      height_q     <= 16'h0000;
      filter_sel_q <= 4'h0;
      err_q        <= 1'b0;
      frame_cnt_q  <= 16'h0000;
      remaining_q  <= '0;
    end else begin
      state_q      <= state_d;
      hdr_idx_q    <= hdr_idx_d;
      filt_id_q    <= filt_id_d;
      width_q      <= width_d;
      height_q     <= height_d;
      filter_sel_q <= filter_sel_d;
      err_q        <= err_d;
      frame_cnt_q  <= frame_cnt_d;
      remaining_q  <= remaining_d;
    end
  end

endmodule

// File: tb/tb_frame_ctrl.sv
// Self-checking bench for frame_ctrl: directed scenarios plus randomized
// frames checked against a frame-level reference model.
module tb_frame_ctrl;
  import frame_ctrl_pkg::*;

  localparam int MAXD = 16;
  localparam int TO   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  sw_filter = 4'h0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        pix_last, busy, err;
  logic [3:0]  filter_sel;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int rdy_mode = 0;
  int stall = 0;
  int gap_max = 0;
  int inv_bad = 0;

  logic [7:0] mon_d[$];
  logic       mon_l[$];
  logic [7:0] exp_d[$];
  logic       exp_l[$];
  logic [7:0] tx_pix[$];

  int         exp_frames = 0;
  logic       exp_err = 1'b0;
  logic [3:0] exp_filt = 4'h0;

  axis_if #(.W(8)) bus_i ();
  axis_if #(.W(8)) bus_o ();

  assign bus_i.tdata  = in_data;
  assign bus_i.tvalid = in_valid;
  assign bus_o.tready = out_ready;

  frame_ctrl #(
    .MAX_DIM        (MAXD),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_filter  (sw_filter),
    .axis_i     (bus_i.slave),
    .axis_o     (bus_o.master),
    .pix_last   (pix_last),
    .filter_sel (filter_sel),
    .busy       (busy),
    .err        (err),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  // Record every output beat; tally invariant violations seen on any cycle.
  always @(negedge clk) begin
    if (bus_o.tvalid && bus_o.tready) begin
      mon_d.push_back(bus_o.tdata);
      mon_l.push_back(pix_last);
    end
    if ((pix_last && !bus_o.tvalid) ||
        (bus_o.tvalid && (bus_o.tdata !== in_data)) ||
        (!busy && bus_o.tvalid))
      inv_bad++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    acc = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int n = 0; n < 64 && !acc; n++) begin
      if (rdy_mode == 1) begin
        out_ready = ~out_ready;
      end else if (rdy_mode == 2) begin
        out_ready = (stall >= 3) || ($urandom_range(0, 3) != 0);
        stall     = out_ready ? 0 : stall + 1;
      end
      @(negedge clk);
      acc = bus_i.tready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (!acc) begin
      n_bad++;
      $display("FAIL send_byte: byte %02h not accepted within 64 cycles", b);
    end
  endtask

  task automatic send_hdr(input logic [7:0] fid, input logic [15:0] w, input logic [15:0] h);
    send_byte(MAGIC);
    send_byte(fid);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(h[7:0]);
    send_byte(h[15:8]);
  endtask

  // Sends a whole frame (random pixels if tx_pix is empty) and updates the model.
  task automatic send_frame(input logic [7:0] fid, input logic [15:0] w, input logic [15:0] h);
    int  n;
    bit  ok;
    ok = (w >= 16'd1) && (w <= 16'(MAXD)) && (h >= 16'd1) && (h <= 16'(MAXD));
    send_hdr(fid, w, h);
    if (!ok) begin
      exp_err = 1'b1;
      tx_pix.delete();
      return;
    end
    n = int'(w) * int'(h);
    if (tx_pix.size() == 0)
      for (int i = 0; i < n; i++)
        tx_pix.push_back(($urandom_range(0, 7) == 0) ? MAGIC : 8'($urandom));
    exp_err  = 1'b0;
    exp_filt = (fid == 8'hFF) ? sw_filter : fid[3:0];
    for (int i = 0; i < n; i++) begin
      exp_d.push_back(tx_pix[i]);
      exp_l.push_back(i == n - 1);
      send_byte(tx_pix[i]);
      if (gap_max > 0) idle($urandom_range(0, gap_max));
    end
    exp_frames++;
    tx_pix.delete();
  endtask

  task automatic clear_q();
    mon_d.delete(); mon_l.delete(); exp_d.delete(); exp_l.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    idle(3);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (frame_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_frame_cnt: got %0h want 0", frame_cnt); end
    n_cmp++; if (filter_sel !== 4'h0) begin n_bad++; $display("FAIL reset_filter_sel: got %0h want 0", filter_sel); end
    n_cmp++; if ({bus_o.tvalid, pix_last} !== 2'b00) begin n_bad++; $display("FAIL reset_tvalid_last: got %b want 00", {bus_o.tvalid, pix_last}); end
    rst = 1'b0;
    idle(1);
    n_cmp++; if (bus_i.tready !== 1'b1) begin n_bad++; $display("FAIL idle_tready: got %b want 1", bus_i.tready); end
  endtask

  task automatic test_basic();
    clear_q();
    for (int i = 0; i < 8; i++) tx_pix.push_back(8'(8'h10 + i));
    send_frame(8'h03, 16'd4, 16'd2);
    idle(2);
    n_cmp++;
    if (mon_d.size() != exp_d.size()) begin n_bad++; $display("FAIL basic_beats: got %0d want %0d", mon_d.size(), exp_d.size()); end
    else foreach (exp_d[i]) begin
      n_cmp++;
      if ({mon_l[i], mon_d[i]} !== {exp_l[i], exp_d[i]}) begin n_bad++; $display("FAIL basic_beat%0d: got last=%b data=%02h want last=%b data=%02h", i, mon_l[i], mon_d[i], exp_l[i], exp_d[i]); end
    end
    n_cmp++; if (filter_sel !== 4'h3) begin n_bad++; $display("FAIL basic_filter_sel: got %0h want 3", filter_sel); end
    n_cmp++; if (frame_cnt !== 16'(exp_frames)) begin n_bad++; $display("FAIL basic_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    n_cmp++; if ({busy, err} !== 2'b00) begin n_bad++; $display("FAIL basic_busy_err: got %b want 00", {busy, err}); end
  endtask

  task automatic test_sw_filter();
    clear_q();
    sw_filter = 4'h6;
    send_hdr(8'hFF, 16'd2, 16'd1);
    // now in the one-cycle header check
    n_cmp++; if ({busy, bus_i.tready} !== 2'b10) begin n_bad++; $display("FAIL check_busy_tready: got %b want 10", {busy, bus_i.tready}); end
    n_cmp++; if (filter_sel !== exp_filt) begin n_bad++; $display("FAIL check_filter_hold: got %0h want %0h", filter_sel, exp_filt); end
    idle(1);
    exp_filt = 4'h6; exp_err = 1'b0;
    n_cmp++; if (filter_sel !== 4'h6) begin n_bad++; $display("FAIL sw_filter_stream: got %0h want 6", filter_sel); end
    send_byte(8'h5C);
    sw_filter = 4'h9;
    send_byte(8'hC5);
    exp_frames++;
    idle(3);
    n_cmp++; if (filter_sel !== 4'h6) begin n_bad++; $display("FAIL sw_filter_hold: got %0h want 6", filter_sel); end
    n_cmp++; if (frame_cnt !== 16'(exp_frames)) begin n_bad++; $display("FAIL sw_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    send_frame(8'h02, 16'd17, 16'd1);
    idle(2);
    n_cmp++; if ({err, filter_sel} !== {1'b1, 4'h6}) begin n_bad++; $display("FAIL bad_hdr_keeps_filter: got err=%b sel=%0h want err=1 sel=6", err, filter_sel); end
    send_frame(8'h02, 16'd1, 16'd1);
    idle(1);
    n_cmp++; if ({err, filter_sel} !== {1'b0, 4'h2}) begin n_bad++; $display("FAIL next_hdr_filter: got err=%b sel=%0h want err=0 sel=2", err, filter_sel); end
  endtask

  task automatic test_bad_header();
    clear_q();
    send_frame(8'h01, 16'd0, 16'd2);
    idle(2);
    n_cmp++; if ({err, busy} !== 2'b10) begin n_bad++; $display("FAIL width0_err_busy: got %b want 10", {err, busy}); end
    n_cmp++; if (mon_d.size() != 0) begin n_bad++; $display("FAIL width0_beats: got %0d want 0", mon_d.size()); end
    n_cmp++; if (frame_cnt !== 16'(exp_frames)) begin n_bad++; $display("FAIL width0_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
    idle(1);
    n_cmp++; if ({err, busy} !== 2'b10) begin n_bad++; $display("FAIL err_sticky: got %b want 10", {err, busy}); end
    send_frame(8'h01, 16'd16, 16'd1);
    idle(1);
    n_cmp++; if ({err, frame_cnt} !== {1'b0, 16'(exp_frames)}) begin n_bad++; $display("FAIL maxdim_ok: got err=%b cnt=%0d want err=0 cnt=%0d", err, frame_cnt, exp_frames); end
    send_frame(8'h01, 16'd1, 16'h0100);
    idle(2);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL height_hi_err: got %b want 1", err); end
    send_frame(8'h01, 16'd17, 16'd1);
    idle(2);
    n_cmp++; if ({err, frame_cnt} !== {1'b1, 16'(exp_frames)}) begin n_bad++; $display("FAIL width17_err: got err=%b cnt=%0d want err=1 cnt=%0d", err, frame_cnt, exp_frames); end
    n_cmp++; if (mon_d.size() != 16) begin n_bad++; $display("FAIL bad_hdr_total_beats: got %0d want 16", mon_d.size()); end
  endtask

  task automatic test_backpressure();
    clear_q();
    tx_pix.push_back(8'h11); tx_pix.push_back(MAGIC); tx_pix.push_back(8'h33); tx_pix.push_back(8'h44);
    out_ready = 1'b0;
    rdy_mode  = 1;
    send_frame(8'h05, 16'd2, 16'd2);
    rdy_mode  = 0;
    out_ready = 1'b1;
    idle(2);
    n_cmp++;
    if (mon_d.size() != exp_d.size()) begin n_bad++; $display("FAIL bp_beats: got %0d want %0d", mon_d.size(), exp_d.size()); end
    else foreach (exp_d[i]) begin
      n_cmp++;
      if ({mon_l[i], mon_d[i]} !== {exp_l[i], exp_d[i]}) begin n_bad++; $display("FAIL bp_beat%0d: got last=%b data=%02h want last=%b data=%02h", i, mon_l[i], mon_d[i], exp_l[i], exp_d[i]); end
    end
    n_cmp++; if ({frame_cnt, filter_sel} !== {16'(exp_frames), 4'h5}) begin n_bad++; $display("FAIL bp_cnt_sel: got %0d/%0h want %0d/5", frame_cnt, filter_sel, exp_frames); end
  endtask

  task automatic test_timeout();
    clear_q();
    send_hdr(8'h07, 16'd2, 16'd2);
    exp_filt = 4'h7; exp_err = 1'b0;
    send_byte(8'hAA); send_byte(8'hBB);
    idle(TO - 1);
    n_cmp++; if ({busy, err} !== 2'b10) begin n_bad++; $display("FAIL timeout_early: got busy,err=%b want 10", {busy, err}); end
    idle(1);
    n_cmp++; if ({busy, err} !== 2'b01) begin n_bad++; $display("FAIL timeout_fire: got busy,err=%b want 01", {busy, err}); end
    n_cmp++; if ({frame_cnt, filter_sel} !== {16'(exp_frames), 4'h7}) begin n_bad++; $display("FAIL timeout_cnt_sel: got %0d/%0h want %0d/7", frame_cnt, filter_sel, exp_frames); end
    n_cmp++; if (mon_d.size() != 2) begin n_bad++; $display("FAIL timeout_beats: got %0d want 2", mon_d.size()); end
    send_frame(8'h02, 16'd1, 16'd1);
    idle(1);
    n_cmp++; if ({err, frame_cnt} !== {1'b0, 16'(exp_frames)}) begin n_bad++; $display("FAIL timeout_recover: got err=%b cnt=%0d want err=0 cnt=%0d", err, frame_cnt, exp_frames); end
  endtask

  task automatic test_last_vs_timeout();
    clear_q();
    send_hdr(8'h04, 16'd2, 16'd2);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    idle(TO - 1);
    send_byte(8'h04);
    exp_frames++;
    idle(1);
    n_cmp++; if ({busy, err, frame_cnt} !== {2'b00, 16'(exp_frames)}) begin n_bad++; $display("FAIL last_beats_timeout: got busy=%b err=%b cnt=%0d want 0 0 %0d", busy, err, frame_cnt, exp_frames); end
    n_cmp++; if (mon_d.size() != 4 || mon_l[mon_l.size()-1] !== 1'b1) begin n_bad++; $display("FAIL last_vs_timeout_beats: got %0d beats want 4 with last", mon_d.size()); end
  endtask

  task automatic test_mid_reset();
    clear_q();
    send_hdr(8'h09, 16'd2, 16'd2);
    send_byte(8'h61);
    rst = 1'b1; in_data = 8'h22; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if ({busy, err, frame_cnt, filter_sel} !== {2'b00, 16'h0, 4'h0}) begin n_bad++; $display("FAIL midrst_state: got busy=%b err=%b cnt=%0d sel=%0h want 0 0 0 0", busy, err, frame_cnt, filter_sel); end
    n_cmp++; if ({bus_o.tvalid, pix_last} !== 2'b00) begin n_bad++; $display("FAIL midrst_tvalid: got %b want 00", {bus_o.tvalid, pix_last}); end
    in_valid = 1'b0;
    exp_frames = 0; exp_err = 1'b0; exp_filt = 4'h0;
    clear_q();
    send_byte(8'h62); send_byte(8'h63); send_byte(8'h64);
    idle(2);
    n_cmp++; if ({mon_d.size() != 0, busy} !== 2'b00) begin n_bad++; $display("FAIL midrst_leftover: got %0d beats busy=%b want 0 0", mon_d.size(), busy); end
    send_frame(8'h01, 16'd2, 16'd2);
    idle(1);
    n_cmp++; if (frame_cnt !== 16'd1) begin n_bad++; $display("FAIL midrst_next_frame: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_random();
    logic [15:0] w, h;
    logic [7:0]  g;
    clear_q();
    rdy_mode = 2;
    gap_max  = 2;
    for (int f = 0; f < 12; f++) begin
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        g = 8'($urandom);
        send_byte((g == MAGIC) ? 8'h5A : g);
      end
      sw_filter = 4'($urandom);
      case ($urandom_range(0, 9))
        0:       w = 16'd0;
        1:       w = 16'(MAXD + 1 + $urandom_range(0, 20));
        default: w = 16'($urandom_range(1, MAXD));
      endcase
      h = ($urandom_range(0, 9) == 0) ? (16'($urandom) | 16'h0100) : 16'($urandom_range(1, MAXD));
      send_frame(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom), w, h);
      idle(1);
      n_cmp++;
      if ({err, filter_sel, frame_cnt} !== {exp_err, exp_filt, 16'(exp_frames)}) begin
        n_bad++;
        $display("FAIL rand_frame%0d: got err=%b sel=%0h cnt=%0d want err=%b sel=%0h cnt=%0d", f, err, filter_sel, frame_cnt, exp_err, exp_filt, exp_frames);
      end
    end
    rdy_mode = 0; gap_max = 0; out_ready = 1'b1;
    idle(3);
    n_cmp++;
    if (mon_d.size() != exp_d.size()) begin n_bad++; $display("FAIL rand_beats: got %0d want %0d", mon_d.size(), exp_d.size()); end
    else foreach (exp_d[i]) begin
      n_cmp++;
      if ({mon_l[i], mon_d[i]} !== {exp_l[i], exp_d[i]}) begin n_bad++; $display("FAIL rand_beat%0d: got last=%b data=%02h want last=%b data=%02h", i, mon_l[i], mon_d[i], exp_l[i], exp_d[i]); end
    end
  endtask

  task automatic test_invariants();
    n_cmp++;
    if (inv_bad != 0) begin n_bad++; $display("FAIL stream_invariants: got %0d violating cycles want 0", inv_bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sw_filter();
    test_bad_header();
    test_backpressure();
    test_timeout();
    test_last_vs_timeout();
    test_mid_reset();
    test_random();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_ctrl.md
FRAME_CTRL -- requirements
Module: frame_ctrl

Interface
REQ-001 SHALL have parameter MAX_DIM, default 1024, the maximum accepted image width and height in pixels.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50_000_000, the maximum number of clk cycles without an accepted input beat inside a frame.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-005 SHALL have port sw_filter, input, 4, the fallback filter select from the board switches.
REQ-006 SHALL have port axis_i, axis_if slave, 8-bit (tdata/tvalid/tready), the byte stream from the UART RX.
REQ-007 SHALL have port axis_o, axis_if master, 8-bit (tdata/tvalid/tready), the pixel stream to the data path.
REQ-008 SHALL have port pix_last, output, 1, high with the final pixel beat of a frame on axis_o.
REQ-009 SHALL have port filter_sel, output, 4, the filter select driven to the data path.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port err, output, 1, a sticky flag for a protocol error or timeout.
REQ-012 SHALL have port frame_cnt, output, 16, the count of completed frames; it wraps at 16'hFFFF.

Function
REQ-013 SHALL implement states IDLE, HDR, CHECK and STREAM.
REQ-014 IDLE: axis_i.tready=1; SHALL discard bytes until MAGIC (8'hA5) is accepted, then go to HDR.
REQ-015 HDR: axis_i.tready=1; SHALL capture 5 bytes in order: filter id, width lo, width hi, height lo, height hi; after the 5th byte, go to CHECK.
REQ-016 CHECK: SHALL last exactly 1 cycle with axis_i.tready=0.
REQ-017 CHECK: SHALL compute total = width*height as a 21-bit unsigned value.
REQ-018 CHECK: if width or height is 0 or greater than MAX_DIM, SHALL set err and go to IDLE; otherwise SHALL clear err and go to STREAM.
REQ-019 CHECK: on a valid header, SHALL load filter_sel with the header filter id[3:0], or with sw_filter if the filter id is 8'hFF.
REQ-020 filter_sel SHALL change only in CHECK, so it is constant for the whole frame.
REQ-021 STREAM: axis_o.tdata=axis_i.tdata, axis_o.tvalid=axis_i.tvalid and axis_i.tready=axis_o.tready, all combinational with zero latency.
REQ-022 STREAM: no byte SHALL be dropped or duplicated.
REQ-023 STREAM: a 21-bit remaining counter SHALL load total in CHECK and decrement on each axis_o handshake (tvalid&&tready).
REQ-024 pix_last SHALL equal axis_o.tvalid && (remaining==1).
REQ-025 STREAM: a handshake with remaining==1 SHALL increment frame_cnt in that cycle and go to IDLE in the next cycle.
REQ-026 A MAGIC byte inside STREAM SHALL be treated as pixel data.
REQ-027 Outside STREAM, axis_o.tvalid SHALL be 0 and pix_last SHALL be 0.
REQ-028 An idle timer SHALL count cycles in HDR and STREAM, clear on every axis_i handshake and clear on every state change.
REQ-029 When the idle timer reaches TIMEOUT_CYCLES-1, the block SHALL set err and go to IDLE.
REQ-030 If a timeout and a final-pixel handshake occur in the same cycle, the handshake SHALL win: frame counted, err unchanged.
REQ-031 err SHALL stay set until the next valid CHECK.
REQ-032 A timeout or error SHALL NOT change filter_sel.
REQ-033 A timeout or error SHALL NOT change frame_cnt.

Reset
REQ-034 rst SHALL act synchronously on the clk edge and SHALL override all other events in the same cycle.
REQ-035 After reset: state=IDLE, filter_sel=4'h0, busy=0, err=0, frame_cnt=0, remaining=0, idle timer=0, axis_o.tvalid=0, pix_last=0.
REQ-036 Reset in the middle of a frame SHALL abandon the frame without counting it; the next frame requires a new header.

Structure
REQ-037 Package frame_ctrl_pkg SHALL hold the state enum, MAGIC=8'hA5, HDR_LEN=5 and the 21-bit pixel-count typedef.
REQ-038 The idle timer SHALL be a sub-module idle_timer (ports clk, rst, clear, expired) parameterised by TIMEOUT_CYCLES.
REQ-039 frame_ctrl SHALL be placed between the UART RX stream and the data path.

Verification
REQ-040 Bench SHALL check: A5 03 04 00 02 00 then 8 pixels, axis_o.tready=1 -> 8 beats out, pix_last on beat 8 only, filter_sel=3, frame_cnt=1.
REQ-041 Bench SHALL check: header filter id FF with sw_filter=4'h6 -> filter_sel=6 from CHECK until the next valid header.
REQ-042 Bench SHALL check: A5 00 00 00 02 00 (width 0) -> err=1, state IDLE, no axis_o beats, frame_cnt unchanged.
REQ-043 Bench SHALL check: 2x2 frame with axis_o.tready toggling 1-0-1-0 and pixel A5 included -> exactly 4 beats in order, A5 passed through.
REQ-044 Bench SHALL check: TIMEOUT_CYCLES=16, stall after 2 of 4 pixels -> err=1 and busy=0 after 16 idle cycles; the next valid frame clears err.
REQ-045 Bench SHALL check: rst pulse after pixel 1 of 4 -> all outputs at reset values next cycle; a following full frame gives frame_cnt=1.
